// File: rtl/dds_wave_ctrl_pkg.sv
// Shared waveform codes, controller state encoding and small helpers for the DDS wave controller.
package dds_wave_ctrl_pkg;

  localparam logic [1:0] WAVE_SIN = 2'b00;
  localparam logic [1:0] WAVE_SQR = 2'b01;
  localparam logic [1:0] WAVE_TRI = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  // The unused request code 11 selects the sine table.
  function automatic logic [1:0] wave_map(input logic [1:0] req);
    return (req == 2'b11) ? WAVE_SIN : req;
  endfunction

  function automatic logic [1:0] wave_succ(input logic [1:0] w);
    case (w)
      WAVE_SIN: return WAVE_SQR;
      WAVE_SQR: return WAVE_TRI;
      default:  return WAVE_SIN;
    endcase
  endfunction

endpackage

// File: rtl/dds_wave_ctrl_phase_acc.sv
// Phase accumulator: carry becomes a registered wrap pulse, ROM address is registered from the phase.
// Address and sample_vld trail the phase update by one cycle; holds everything while en_i is low.
module dds_wave_ctrl_phase_acc #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [PHASE_W-1:0] freq_i,
  output logic [ADDR_W-1:0]  rom_addr_o,
  output logic               sample_vld_o,
  output logic               wrap_o
);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W:0]   phase_d;
  logic [ADDR_W-1:0]  addr_q;
  logic               adv_d, adv_q;
  logic               svld_q;
  logic               wrap_q;

  assign phase_d = {1'b0, phase_q} + {1'b0, freq_i};
  // A zero increment leaves the phase untouched, so it does not count as a new sample.
  assign adv_d   = en_i & (freq_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      addr_q  <= '0;
      adv_q   <= 1'b0;
      svld_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      if (en_i) begin
        phase_q <= phase_d[PHASE_W-1:0];
      end
      wrap_q <= en_i & phase_d[PHASE_W];
      adv_q  <= adv_d;
      svld_q <= adv_q;
      addr_q <= phase_q[PHASE_W-1 -: ADDR_W];
    end
  end

  assign rom_addr_o   = addr_q;
  assign sample_vld_o = svld_q;
  assign wrap_o       = wrap_q;

endmodule

// File: rtl/dds_wave_ctrl.sv
// DDS sequencer: wave/frequency changes are shadowed and committed only at a phase wrap.
// Optional WAVE_AUTO_CYCLE_EN: rotate sin->square->tri every AUTO_WRAPS wraps.
module dds_wave_ctrl
  import dds_wave_ctrl_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 8
`ifdef WAVE_AUTO_CYCLE_EN
  ,
  parameter int AUTO_WRAPS = 16
`endif
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [1:0]         wave_req_i,
  input  logic               wave_vld_i,
  output logic               wave_rdy_o,
  input  logic [PHASE_W-1:0] freq_word_i,
  input  logic               freq_load_i,
  output logic [1:0]         wave_o,
  output logic [ADDR_W-1:0]  rom_addr_o,
  output logic               sample_vld_o,
  output logic               wrap_o,
  output logic               pending_o
);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] freq_act_q, freq_act_d;
  logic [PHASE_W-1:0] freq_shd_q, freq_shd_d;
  logic               freq_pend_q, freq_pend_d;
  logic [1:0]         wave_q, wave_d;
  logic [1:0]         wave_nxt_q, wave_nxt_d;
  logic               wave_pend_q, wave_pend_d;
  logic               wave_rdy_q;
  logic               pending_q;
  logic               wrap;
  logic               wave_acc, wave_apply, freq_apply;
`ifdef WAVE_AUTO_CYCLE_EN
  logic [15:0]        cnt_q, cnt_d;
`endif

  dds_wave_ctrl_phase_acc #(
    .PHASE_W (PHASE_W),
    .ADDR_W  (ADDR_W)
  ) u_acc (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .freq_i       (freq_act_q),
    .rom_addr_o   (rom_addr_o),
    .sample_vld_o (sample_vld_o),
    .wrap_o       (wrap)
  );

  // Only changes pending before the wrap cycle are committed by it.
  assign wave_acc   = wave_vld_i & wave_rdy_q;
  assign wave_apply = wrap & wave_pend_q;
  assign freq_apply = wrap & freq_pend_q;

  always_comb begin
    freq_shd_d  = freq_load_i ? freq_word_i : freq_shd_q;
    freq_act_d  = freq_act_q;
    freq_pend_d = freq_pend_q;
    if (state_q == ST_IDLE) begin
      // Nothing is running, so there is no period to protect.
      if (freq_load_i) begin
        freq_act_d = freq_word_i;
      end else if (freq_pend_q) begin
        freq_act_d = freq_shd_q;
      end
      freq_pend_d = 1'b0;
    end else if (freq_apply) begin
      freq_act_d  = freq_shd_q;
      freq_pend_d = freq_load_i;
    end else if (freq_load_i) begin
      freq_pend_d = 1'b1;
    end

    wave_nxt_d  = wave_acc ? wave_map(wave_req_i) : wave_nxt_q;
    wave_pend_d = wave_acc | (wave_pend_q & ~wave_apply);
    wave_d      = wave_q;
`ifdef WAVE_AUTO_CYCLE_EN
    cnt_d = cnt_q;
    if (wave_apply) begin
      wave_d = wave_nxt_q;
      cnt_d  = '0;
    end else if (wrap) begin
      if (cnt_q == 16'(AUTO_WRAPS - 1)) begin
        wave_d = wave_succ(wave_q);
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
`else
    if (wave_apply) begin
      wave_d = wave_nxt_q;
    end
`endif

    if (freq_act_d == '0) begin
      state_d = ST_IDLE;
    end else if (wave_pend_d | freq_pend_d) begin
      state_d = ST_PEND;
    end else begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      freq_act_q  <= '0;
      freq_shd_q  <= '0;
      freq_pend_q <= 1'b0;
      wave_q      <= WAVE_SIN;
      wave_nxt_q  <= WAVE_SIN;
      wave_pend_q <= 1'b0;
      wave_rdy_q  <= 1'b1;
      pending_q   <= 1'b0;
`ifdef WAVE_AUTO_CYCLE_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      freq_act_q  <= freq_act_d;
      freq_shd_q  <= freq_shd_d;
      freq_pend_q <= freq_pend_d;
      wave_q      <= wave_d;
      wave_nxt_q  <= wave_nxt_d;
      wave_pend_q <= wave_pend_d;
      wave_rdy_q  <= ~wave_pend_d;
      pending_q   <= wave_pend_d | freq_pend_d;
`ifdef WAVE_AUTO_CYCLE_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign wave_o     = wave_q;
  assign wave_rdy_o = wave_rdy_q;
  assign wrap_o     = wrap;
  assign pending_o  = pending_q;

endmodule
